onewire_tx_engine: RTL and testbench

//  Downstream consumer of the 8-bit TX byte fifo. Pulls one byte at a time over the fifo read handshake.

---
 rtl/onewire_tx_engine_pkg.sv | 25 ++
 rtl/onewire_tx_engine_timer.sv | 25 ++
 rtl/onewire_tx_engine.sv | 152 +++++++++++++++
 tb/tb_onewire_tx_engine.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/onewire_tx_engine_pkg.sv
// Shared 1-wire timing constants (in microseconds) and FSM state encoding,
// common to the TX engine and the future read-slot engine.
package onewire_tx_engine_pkg;

  localparam int W1L_US  = 6;
  localparam int W0L_US  = 60;
  localparam int SLOT_US = 70;
  localparam int RSTL_US = 480;
  localparam int MSP_US  = 70;
  localparam int RSTH_US = 410;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_BIT_LOW,
    ST_BIT_REC,
    ST_RST_LOW,
    ST_RST_WAIT
  } state_t;

  function automatic int us2clk(input int us, input int clks_per_us);
    return us * clks_per_us;
  endfunction

endpackage

// File: rtl/onewire_tx_engine_timer.sv
// Loadable down-counter; done while the count sits at zero.
module onewire_tx_engine_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             done
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/onewire_tx_engine.sv
// 1-wire write-slot serialiser fed from the TX byte fifo, with bus reset and
// presence detect; drives the open-drain pad enable.
module onewire_tx_engine
  import onewire_tx_engine_pkg::*;
#(
  parameter int CLKS_PER_US = 100,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic              fifo_do_read,
  input  logic              fifo_read_ack,
  input  logic [DATA_W-1:0] fifo_do,
  input  logic              bus_reset_req,
  input  logic              ow_in,
  output logic              ow_drive_low,
  output logic              presence,
  output logic              presence_valid,
  output logic              byte_done,
  output logic              busy
);

  localparam int TW = $clog2(RSTL_US * CLKS_PER_US + 1);
  localparam int BW = $clog2(DATA_W);

  // Timer reloads are length-1 so a state lasts exactly its nominal cycle count.
  localparam logic [TW-1:0] W1L_LD  = TW'(us2clk(W1L_US, CLKS_PER_US) - 1);
  localparam logic [TW-1:0] W0L_LD  = TW'(us2clk(W0L_US, CLKS_PER_US) - 1);
  localparam logic [TW-1:0] W1R_LD  = TW'(us2clk(SLOT_US - W1L_US, CLKS_PER_US) - 1);
  localparam logic [TW-1:0] W0R_LD  = TW'(us2clk(SLOT_US - W0L_US, CLKS_PER_US) - 1);
  localparam logic [TW-1:0] RSTL_LD = TW'(us2clk(RSTL_US, CLKS_PER_US) - 1);
  localparam logic [TW-1:0] RSTH_LD = TW'(us2clk(RSTH_US, CLKS_PER_US) - 1);
  localparam logic [TW-1:0] MSP_CNT = TW'(us2clk(RSTH_US - MSP_US, CLKS_PER_US));
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_t            state, state_nxt;
  logic [TW-1:0]     tmr_ld_val, tmr_cnt;
  logic              tmr_load, tmr_done;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     bit_cnt;
  logic              rst_pending;
  logic              ow_in_p0, ow_in_p1;
  logic              presence_sample;
  logic              byte_end;

  onewire_tx_engine_timer #(.WIDTH(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_ld_val),
    .count    (tmr_cnt),
    .done     (tmr_done)
  );

  always_comb begin
    state_nxt  = state;
    tmr_ld_val = '0;
    unique case (state)
      ST_IDLE: begin
        if (rst_pending || bus_reset_req) begin
          state_nxt  = ST_RST_LOW;
          tmr_ld_val = RSTL_LD;
        end else begin
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (fifo_read_ack) begin
          state_nxt  = ST_BIT_LOW;
          tmr_ld_val = fifo_do[0] ? W1L_LD : W0L_LD;
        end else if (bus_reset_req) begin
          state_nxt  = ST_RST_LOW;
          tmr_ld_val = RSTL_LD;
        end
      end
      ST_BIT_LOW: begin
        if (tmr_done) begin
          state_nxt  = ST_BIT_REC;
          tmr_ld_val = shreg[0] ? W1R_LD : W0R_LD;
        end
      end
      ST_BIT_REC: begin
        if (tmr_done) begin
          if (bit_cnt == LAST_BIT) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt  = ST_BIT_LOW;
            tmr_ld_val = shreg[1] ? W1L_LD : W0L_LD;
          end
        end
      end
      ST_RST_LOW: begin
        if (tmr_done) begin
          state_nxt  = ST_RST_WAIT;
          tmr_ld_val = RSTH_LD;
        end
      end
      ST_RST_WAIT: begin
        if (tmr_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign tmr_load        = (state_nxt != state);
  assign byte_end        = (state == ST_BIT_REC) && tmr_done && (bit_cnt == LAST_BIT);
  assign presence_sample = (state == ST_RST_WAIT) && (tmr_cnt == MSP_CNT);

  // Stage p0/p1: two-flop synchroniser on the raw bus level, idle high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      rst_pending    <= 1'b0;
      bit_cnt        <= '0;
      ow_in_p0       <= 1'b1;
      ow_in_p1       <= 1'b1;
      ow_drive_low   <= 1'b0;
      fifo_do_read   <= 1'b0;
      busy           <= 1'b0;
      byte_done      <= 1'b0;
      presence       <= 1'b0;
      presence_valid <= 1'b0;
    end else begin
      state          <= state_nxt;
      ow_in_p0       <= ow_in;
      ow_in_p1       <= ow_in_p0;
      ow_drive_low   <= (state_nxt == ST_BIT_LOW) || (state_nxt == ST_RST_LOW);
      fifo_do_read   <= (state_nxt == ST_FETCH);
      busy           <= !((state_nxt == ST_IDLE) || (state_nxt == ST_FETCH));
      byte_done      <= byte_end;
      presence_valid <= presence_sample;
      if (presence_sample) presence <= ~ow_in_p1;
      if (state == ST_FETCH && fifo_read_ack) bit_cnt <= '0;
      else if (state == ST_BIT_REC && tmr_done) bit_cnt <= bit_cnt + 1'b1;
      // A request that cannot start a reset now is remembered until IDLE.
      if (state_nxt == ST_RST_LOW && state != ST_RST_LOW) begin
        rst_pending <= 1'b0;
      end else if (bus_reset_req &&
                   (state == ST_BIT_LOW || state == ST_BIT_REC ||
                    state == ST_RST_LOW || state == ST_RST_WAIT ||
                    (state == ST_FETCH && fifo_read_ack))) begin
        rst_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_FETCH && fifo_read_ack) shreg <= fifo_do;
    else if (state == ST_BIT_REC && tmr_done) shreg <= shreg >> 1;
  end

endmodule

// File: tb/tb_onewire_tx_engine.sv
// Directed/randomised bench for onewire_tx_engine: records bus low pulses and
// event times, compares them with slot timings computed from the byte values.
module tb_onewire_tx_engine;

  localparam int CPU = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       fifo_do_read, fifo_read_ack;
  logic [7:0] fifo_do;
  logic       bus_reset_req, ow_in;
  logic       ow_drive_low, presence, presence_valid, byte_done, busy;

  always #5 clk = ~clk;

  onewire_tx_engine #(.CLKS_PER_US(CPU), .DATA_W(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .fifo_do_read   (fifo_do_read),
    .fifo_read_ack  (fifo_read_ack),
    .fifo_do        (fifo_do),
    .bus_reset_req  (bus_reset_req),
    .ow_in          (ow_in),
    .ow_drive_low   (ow_drive_low),
    .presence       (presence),
    .presence_valid (presence_valid),
    .byte_done      (byte_done),
    .busy           (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rise_t = 0;
  int rd_viol = 0;
  int low_t[$], low_w[$], rel_t[$], bd_t[$], pv_t[$], pv_v[$], bfall_t[$], rd_t[$];
  logic [7:0] fifo_q[$];
  logic prev_drv = 1'b0;
  logic prev_busy = 1'b0;

  // Bus/event recorder, sampled 1 ns after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (ow_drive_low === 1'b1 && !prev_drv) begin
        rise_t = cyc;
        low_t.push_back(cyc);
      end
      if (ow_drive_low === 1'b0 && prev_drv) begin
        low_w.push_back(cyc - rise_t);
        rel_t.push_back(cyc);
      end
      if (byte_done === 1'b1) bd_t.push_back(cyc);
      if (presence_valid === 1'b1) begin
        pv_t.push_back(cyc);
        pv_v.push_back(int'(presence));
      end
      if (busy === 1'b0 && prev_busy) bfall_t.push_back(cyc);
      if (busy === 1'b1 && fifo_do_read === 1'b1) rd_viol++;
      prev_drv  = (ow_drive_low === 1'b1);
      prev_busy = (busy === 1'b1);
    end
  end

  // Fifo model: answers a pending read one cycle later with a 1-cycle ack.
  initial begin
    fifo_read_ack = 1'b0;
    fifo_do = 8'h00;
    forever begin
      @(negedge clk);
      if (fifo_read_ack) begin
        fifo_read_ack = 1'b0;
      end else if (fifo_do_read === 1'b1 && reset === 1'b0 && fifo_q.size() > 0) begin
        fifo_do = fifo_q.pop_front();
        fifo_read_ack = 1'b1;
        rd_t.push_back(cyc);
      end
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    low_t.delete(); low_w.delete(); rel_t.delete(); bd_t.delete();
    pv_t.delete(); pv_v.delete(); bfall_t.delete(); rd_t.delete();
    rd_viol = 0;
  endtask

  task automatic wait_idle(input int limit);
    int quiet = 0;
    for (int i = 0; i < limit && quiet < 3; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && fifo_q.size() == 0) quiet++;
      else quiet = 0;
    end
    check("idle_reached", int'(quiet >= 3), 1);
  endtask

  task automatic pulse_req();
    @(negedge clk);
    bus_reset_req = 1'b1;
    @(negedge clk);
    bus_reset_req = 1'b0;
  endtask

  // Expected slot i of byte b: low 6us for a 1, 60us for a 0; slots 70us apart.
  task automatic check_byte(input logic [7:0] b, input int base);
    check("slot_count", int'(low_w.size() >= base + 8), 1);
    if (low_w.size() >= base + 8) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("low_w[%0d]", base + i), low_w[base + i],
              ((b >> i) & 8'h01) != 0 ? 6 * CPU : 60 * CPU);
        if (i > 0)
          check($sformatf("slot_period[%0d]", base + i),
                low_t[base + i] - low_t[base + i - 1], 70 * CPU);
      end
    end
  endtask

  task automatic presence_run(input logic device);
    int s, e, got;
    s = int'($urandom_range(10, 110));
    e = int'($urandom_range(160, 400));
    clear_logs();
    pulse_req();
    got = 0;
    for (int i = 0; i < 1200 && got == 0; i++) begin
      @(negedge clk);
      if (rel_t.size() > 0) got = 1;
    end
    check("rst_release_seen", got, 1);
    if (device) begin
      repeat (s) @(negedge clk);
      ow_in = 1'b0;
      repeat (e - s) @(negedge clk);
      ow_in = 1'b1;
    end
    wait_idle(2000);
    check("rst_low_width", low_w.size() > 0 ? low_w[0] : -1, 480 * CPU);
    check("pv_count", pv_t.size(), 1);
    if (pv_t.size() > 0 && rel_t.size() > 0) begin
      check("pv_time", pv_t[0] - rel_t[0], 70 * CPU);
      check("pv_value", pv_v[0], int'(device && (s + 3 <= 70 * CPU) && (e >= 70 * CPU)));
    end
    check("presence_held", int'(presence), int'(device));
    if (bfall_t.size() > 0 && rel_t.size() > 0)
      check("rst_total_high", bfall_t[0] - rel_t[0], 410 * CPU);
    else
      check("busy_fall_seen", bfall_t.size(), 1);
  endtask

  initial begin
    logic [7:0] bytes[$];
    int got;
    reset = 1'b1;
    bus_reset_req = 1'b0;
    ow_in = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_drive", int'(ow_drive_low), 0);
    check("rst_read", int'(fifo_do_read), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_bdone", int'(byte_done), 0);
    check("rst_pres", int'(presence), 0);
    check("rst_pvalid", int'(presence_valid), 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("read_req_after_reset", int'(fifo_do_read), 1);

    // Single byte 0x2A
    clear_logs();
    fifo_q.push_back(8'h2A);
    wait_idle(3000);
    check("t1_nslots", low_w.size(), 8);
    check_byte(8'h2A, 0);
    check("t1_bdone_count", bd_t.size(), 1);
    if (bd_t.size() > 0 && low_t.size() >= 8)
      check("t1_bdone_time", bd_t[0] - low_t[7], 70 * CPU);

    // Back-to-back bytes, directed then random
    clear_logs();
    bytes = '{8'h42, 8'h25, 8'h32, 8'($urandom), 8'($urandom)};
    foreach (bytes[k]) fifo_q.push_back(bytes[k]);
    wait_idle(8000);
    check("t2_nslots", low_w.size(), 8 * bytes.size());
    check("t2_bdone_count", bd_t.size(), bytes.size());
    foreach (bytes[k]) check_byte(bytes[k], 8 * k);
    for (int k = 1; k < bytes.size(); k++)
      if (low_t.size() >= 8 * k + 1)
        check("t2_gap_ok", int'(low_t[8 * k] - low_t[8 * k - 1] >= 70 * CPU + 2), 1);
    check("t2_read_while_busy", rd_viol, 0);

    // Bus reset with and without a responding device
    presence_run(1'b1);
    presence_run(1'b0);

    // Reset request during bit 3 of 0xFF, another byte queued behind it
    clear_logs();
    fifo_q.push_back(8'hFF);
    got = 0;
    for (int i = 0; i < 2000 && got == 0; i++) begin
      @(negedge clk);
      if (low_t.size() >= 4) got = 1;
    end
    check("t5_bit3_seen", got, 1);
    pulse_req();
    fifo_q.push_back(8'h5A);
    wait_idle(6000);
    check("t5_nlow", low_w.size(), 17);
    check_byte(8'hFF, 0);
    if (low_w.size() >= 9 && bd_t.size() > 0) begin
      check("t5_rst_width", low_w[8], 480 * CPU);
      check("t5_rst_after_byte", low_t[8] - bd_t[0], 1);
    end
    check("t5_reads", rd_t.size(), 2);
    if (rd_t.size() >= 2 && rel_t.size() >= 9)
      check("t5_no_read_between", int'(rd_t[1] > rel_t[8]), 1);
    check_byte(8'h5A, 9);
    check("t5_pv_count", pv_t.size(), 1);
    check("t5_bdone_count", bd_t.size(), 2);
    check("t5_read_while_busy", rd_viol, 0);

    // Synchronous reset in the middle of a write-0 low phase
    clear_logs();
    fifo_q.push_back(8'h00);
    got = 0;
    for (int i = 0; i < 200 && got == 0; i++) begin
      @(negedge clk);
      if (low_t.size() >= 1) got = 1;
    end
    check("t6_low_seen", got, 1);
    repeat (50) @(negedge clk);
    check("t6_low_before_reset", int'(ow_drive_low), 1);
    reset = 1'b1;
    @(negedge clk);
    check("t6_drive", int'(ow_drive_low), 0);
    check("t6_busy", int'(busy), 0);
    check("t6_read", int'(fifo_do_read), 0);
    check("t6_pvalid", int'(presence_valid), 0);
    check("t6_bdone", int'(byte_done), 0);
    check("t6_pres", int'(presence), 0);
    reset = 1'b0;
    got = 0;
    for (int i = 0; i < 4 && got == 0; i++) begin
      @(negedge clk);
      if (fifo_do_read === 1'b1) got = 1;
    end
    check("t6_read_reasserts", got, 1);
    repeat (1500) @(negedge clk);
    check("t6_no_bdone", bd_t.size(), 0);
    check("t6_no_more_slots", low_t.size(), 1);
    check("t6_idle_drive", int'(ow_drive_low), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
